reg_dst_queue: RTL

- Parametrised successor of the register-destination selector in the MIPS datapath.
- Decodes RegDst into a 5-bit destination combinationally, exactly as before, plus defined handling for unused codes.
- Adds an in-order queue of in-flight destinations. Control pushes on issue and pops on write-back, so the Banco_reg write port always gets the oldest pending destination.
- Also produces RS/RT hazard flags against every pending destination, for stall logic in the control unit.

---
 rtl/reg_dst_defs.sv | 21 ++
 rtl/dst_decode.sv | 33 +++
 rtl/reg_dst_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reg_dst_defs.sv
// Shared RegDst mode encodings and default special-register indices
// for the register-destination decoder and in-flight destination queue.
package reg_dst_defs;

  localparam logic [2:0] RD_RT = 3'd0;
  localparam logic [2:0] RD_RD = 3'd1;
  localparam logic [2:0] RD_SP = 3'd2;
  localparam logic [2:0] RD_RA = 3'd3;
  localparam logic [2:0] RD_RS = 3'd4;
  localparam logic [2:0] RD_K  = 3'd5;

  localparam int DEF_SP_REG = 29;
  localparam int DEF_RA_REG = 31;
  localparam int DEF_K_REG  = 26;

  // Codes above RD_K are unassigned.
  function automatic logic mode_is_illegal(input logic [2:0] mode);
    return mode > RD_K;
  endfunction

endpackage

// File: rtl/dst_decode.sv
// Combinational RegDst decoder: selects the destination register index.
// Zero latency; no flow control. Unused codes yield 0 and flag illegal_mode.
module dst_decode
  import reg_dst_defs::*;
#(
  parameter int ADDR_W = 5,
  parameter int SP_REG = DEF_SP_REG,
  parameter int RA_REG = DEF_RA_REG,
  parameter int K_REG  = DEF_K_REG
) (
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [15:0]       Offset,
  input  logic [2:0]        RegDst,
  output logic [ADDR_W-1:0] reg_dst_out,
  output logic              illegal_mode
);

  always_comb begin
    reg_dst_out  = '0;
    illegal_mode = mode_is_illegal(RegDst);
    case (RegDst)
      RD_RT:   reg_dst_out = RT;
      RD_RD:   reg_dst_out = ADDR_W'(Offset[15:11]);
      RD_SP:   reg_dst_out = ADDR_W'(SP_REG);
      RD_RA:   reg_dst_out = ADDR_W'(RA_REG);
      RD_RS:   reg_dst_out = RS;
      RD_K:    reg_dst_out = ADDR_W'(K_REG);
      default: reg_dst_out = '0;
    endcase
  end

endmodule

// File: rtl/reg_dst_queue.sv
// In-order queue of in-flight destinations with RS/RT hazard compare.
// Decode is zero latency; head appears on wb_dst one cycle after the edge.
module reg_dst_queue
  import reg_dst_defs::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int SP_REG = DEF_SP_REG,
  parameter int RA_REG = DEF_RA_REG,
  parameter int K_REG  = DEF_K_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        RS,
  input  logic [ADDR_W-1:0]        RT,
  input  logic [15:0]              Offset,
  input  logic [2:0]               RegDst,
  input  logic                     issue,
  input  logic                     wb,
  output logic [ADDR_W-1:0]        reg_dst_out,
  output logic [ADDR_W-1:0]        wb_dst,
  output logic                     wb_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hazard_rs,
  output logic                     hazard_rt,
  output logic                     illegal_mode,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic empty, is_full, do_push, do_pop;

  dst_decode #(
    .ADDR_W (ADDR_W),
    .SP_REG (SP_REG),
    .RA_REG (RA_REG),
    .K_REG  (K_REG)
  ) u_dst_decode (
    .RS           (RS),
    .RT           (RT),
    .Offset       (Offset),
    .RegDst       (RegDst),
    .reg_dst_out  (reg_dst_out),
    .illegal_mode (illegal_mode)
  );

  assign empty   = (count_q == '0);
  assign is_full = (count_q == CNT_W'(DEPTH));
  assign do_pop  = wb && !empty;
  // A same-cycle pop frees the slot, so a full queue still accepts the push.
  assign do_push = issue && !illegal_mode && (!is_full || wb);

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wb_dst_d = wb_dst_q;
    ovf_d    = ovf_q || (issue && !illegal_mode && is_full && !wb);
    unf_d    = unf_q || (wb && empty);

    if (do_pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    // Push after pop so a full-queue wrap re-marks the reused slot valid.
    if (do_push) begin
      mem_d[tail_q] = reg_dst_out;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Forward the incoming entry when it becomes the new head this edge.
    if (count_d != '0) begin
      if (do_push && (head_d == tail_q)) wb_dst_d = reg_dst_out;
      else                               wb_dst_d = mem_q[head_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wb_dst_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wb_dst_q <= wb_dst_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i] == RS) && (RS != '0)) hazard_rs = 1'b1;
      if (vld_q[i] && (mem_q[i] == RT) && (RT != '0)) hazard_rt = 1'b1;
    end
  end

  assign wb_dst    = wb_dst_q;
  assign wb_valid  = !empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
